line_window_packer: RTL and testbench
=====================================

// Module: line_window_packer
// PURPOSE
//  Streaming front end of the spatial filter. Takes a raster-order pixel stream, buffers K-1 image lines,
//  and forms a KxK neighbourhood window on every accepted pixel once enough lines and columns exist.
//  Emits the window as one flat packed bus that the filter kernel unpacks into a K*K array of pixels.
//  Valid-only stream: no backpressure.
// PARAMETERS
//  PIX_W  8   bits per pixel
//  IMG_W  64  pixels per line (>= K)
//  IMG_H  64  lines per frame (>= K)
//  K      3   window side; window holds K*K pixels
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              synchronous active-low reset
//  sof         in   1              start of frame; qualifies the pixel on pix_in when pix_valid=1
//  pix_valid   in   1              pix_in carries a pixel this cycle
//  pix_in      in   PIX_W          input pixel, raster order
//  win_valid   out  1              win_out holds a complete window this cycle
//  win_out     out  K*K*PIX_W      packed window; lane i = bits [PIX_W*i +: PIX_W]
//  frame_done  out  1              one-cycle pulse with the window of the frame's last pixel
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge):
//    win_valid=0, frame_done=0, win_out=0; column/row counters=0; window registers=0.
//    Line-buffer RAM contents are don't-care and are never output before being rewritten.
//  - Counters:
//    col 0..IMG_W-1 and row 0..IMG_H-1 advance only on pix_valid=1.
//    col wraps to 0 and row increments at IMG_W-1.
//    At row=IMG_H-1, col=IMG_W-1 both wrap to 0 and the block waits for the next frame.
//  - sof=1 with pix_valid=1: that pixel is col=0,row=0, whatever the counter state.
//    A mid-frame sof aborts the current frame; no window from the aborted frame is emitted afterwards.
//    sof with pix_valid=0 is ignored.
//  - Line buffers: K-1 chained buffers of IMG_W x PIX_W, indexed by col.
//    Each accepted pixel pushes the column's history up one line.
//  - Window: KxK register array.
//    On each accepted pixel all rows shift left by one column.
//    The new right column is {line_buf[K-2]..line_buf[0], pix_in}, oldest row first.
//  - Packing: lane i = r*K + c, with r=0 the oldest line and c=0 the leftmost (oldest) column.
//    The current pixel is lane K*K-1; the top-left pixel is lane 0.
//  - Latency: win_valid=1 on the cycle after an accepted pixel with row>=K-1 and col>=K-1.
//    In that case win_out holds the window whose bottom-right pixel is that pixel.
//    Otherwise win_valid=0.
//    Windows never straddle a line end: the first K-1 columns of each line produce no window.
//  - pix_valid=0: no state changes; win_valid=0 the next cycle; win_out holds its last value.
//  - frame_done=1 together with the win_valid of pixel (row=IMG_H-1, col=IMG_W-1).
//  - Back-to-back frames: pixel 0 of the new frame may directly follow the last pixel of the previous frame.
//    Stale line data is masked by the row>=K-1 rule.
//  - Widths: all counters sized by $clog2 of their bound. No arithmetic on pixel data.
// TESTING
//  (bench params: PIX_W=8, IMG_W=4, IMG_H=4, K=3; pixel value = row*16+col)
//  1. Reset, then stream one full frame with continuous pix_valid.
//     -> exactly 4 windows (rows 2-3, cols 2-3).
//     -> first window lanes 0..8 = 00,01,02,10,11,12,20,21,22, one cycle after pixel 0x22.
//     -> frame_done only with the window ending at 0x33.
//  2. Same frame with pix_valid toggled 1,0,1,0.
//     -> same 4 windows and values as case 1; win_valid never high two cycles after a gap.
//  3. Two frames back-to-back, second frame using values +0x80.
//     -> second frame's first window = 80,81,82,90,91,92,A0,A1,A2.
//     -> no window output during the second frame's rows 0-1.
//  4. sof asserted at row 2 col 1 mid-frame, then a full frame.
//     -> no window output until the new frame's pixel (2,2).
//     -> 4 windows total after the sof.
//  5. rst_n=0 for one cycle mid-frame at row 3, then a full frame with sof.
//     -> win_valid=0, win_out=0 and frame_done=0 the cycle after reset.
//     -> output equals case 1.
//  6. sof=1 with pix_valid=0 mid-frame.
//     -> ignored; the frame completes normally with 4 windows and frame_done.

Source files
------------

// File: rtl/line_window_packer_if.sv
// Pixel-stream and window bundle shared by the window packer and its source/sink.
// The master side drives pixels in; the slave side (the packer) returns windows.
interface line_window_packer_if #(
    parameter int PIX_W = 8,
    parameter int K     = 3
);
    logic                   sof;
    logic                   pix_valid;
    logic [PIX_W-1:0]       pix_in;
    logic                   win_valid;
    logic [K*K*PIX_W-1:0]   win_out;
    logic                   frame_done;

    modport master (
        output sof,
        output pix_valid,
        output pix_in,
        input  win_valid,
        input  win_out,
        input  frame_done
    );

    modport slave (
        input  sof,
        input  pix_valid,
        input  pix_in,
        output win_valid,
        output win_out,
        output frame_done
    );
endinterface

// File: rtl/line_window_packer.sv
// Line-buffered KxK window former for the spatial filter front end.
// Buffers K-1 lines of the raster stream and emits one packed window per
// accepted pixel whose neighbourhood lies entirely inside the current frame.
module line_window_packer #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int K     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    line_window_packer_if.slave bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_colNext;
    logic [ROW_W-1:0] w_rowNext;
    logic             w_lastCol;
    logic             w_lastRow;

    logic [PIX_W-1:0] r_lineBuf [K-1][IMG_W];
    logic [PIX_W-1:0] r_win     [K][K];
    logic [PIX_W-1:0] w_newCol  [K];

    logic             r_winValid;
    logic             r_frameDone;

    // Position of the incoming pixel (sof forces the origin) and where the counters go next
    always_comb begin
        w_col     = bus.sof ? '0 : r_col;
        w_row     = bus.sof ? '0 : r_row;
        w_lastCol = (w_col == COL_W'(IMG_W - 1));
        w_lastRow = (w_row == ROW_W'(IMG_H - 1));
        w_colNext = w_col + COL_W'(1);
        w_rowNext = w_row;
        if (w_lastCol) begin
            w_colNext = '0;
            w_rowNext = w_lastRow ? '0 : (w_row + ROW_W'(1));
        end
    end

    // Raster position counters advance only on accepted pixels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.pix_valid) begin
            r_col <= w_colNext;
            r_row <= w_rowNext;
        end
    end

    // Line buffers: push this column's history up one line; contents need no reset
    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            for (int j = K - 2; j >= 1; j--) begin
                r_lineBuf[j][w_col] <= r_lineBuf[j-1][w_col];
            end
            r_lineBuf[0][w_col] <= bus.pix_in;
        end
    end

    // New right-hand window column, oldest line at the top
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            w_newCol[r] = r_lineBuf[K-2-r][w_col];
        end
        w_newCol[K-1] = bus.pix_in;
    end

    // Window register array shifts left by one column per accepted pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (bus.pix_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][K-1] <= w_newCol[r];
            end
        end
    end

    // Window is complete once K lines and K columns of the current line exist
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_winValid  <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_winValid  <= bus.pix_valid && (w_row >= ROW_W'(K - 1)) && (w_col >= COL_W'(K - 1));
            r_frameDone <= bus.pix_valid && w_lastRow && w_lastCol;
        end
    end

    // Flatten the window: lane r*K+c, top-left oldest pixel in lane 0
    always_comb begin
        bus.win_out = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                bus.win_out[PIX_W*(r*K+c) +: PIX_W] = r_win[r][c];
            end
        end
    end

    assign bus.win_valid  = r_winValid;
    assign bus.frame_done = r_frameDone;
endmodule

// File: tb/tb_line_window_packer.sv
// Self-checking bench for line_window_packer on a 4x4 image with a 3x3 window.
// A frame-image model predicts every window; literal windows pin the model.
module tb_line_window_packer;
    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int K     = 3;
    localparam int WIN_W = K*K*PIX_W;

    logic clk = 1'b0;
    logic rst_n;

    line_window_packer_if #(.PIX_W(PIX_W), .K(K)) bus ();

    line_window_packer #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .K    (K)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model state: picture of the frame in progress plus raster position
    logic [PIX_W-1:0] img [IMG_H][IMG_W];
    int               mRow = 0;
    int               mCol = 0;

    // Expectation for the cycle after the current drive, and the one under check
    logic             pendValid = 1'b0;
    logic             pendFd    = 1'b0;
    logic             pendWinChk = 1'b0;
    logic [WIN_W-1:0] pendWin   = '0;
    logic             curValid  = 1'b0;
    logic             curFd     = 1'b0;
    logic             curWinChk = 1'b0;
    logic [WIN_W-1:0] curWin    = '0;
    bit               checkEn   = 1'b0;

    // Per-case observations
    int               winCount = 0;
    int               fdCount  = 0;
    logic [WIN_W-1:0] seenWins [$];

    task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model predicts what the outputs must be next cycle
    task automatic applyStimulus(input logic r, input logic s, input logic v, input logic [PIX_W-1:0] p);
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.sof       = s;
        bus.pix_valid = v;
        bus.pix_in    = p;
        pendValid  = 1'b0;
        pendFd     = 1'b0;
        pendWinChk = 1'b0;
        if (!r) begin
            pendWin    = '0;
            pendWinChk = 1'b1;
            mRow = 0;
            mCol = 0;
        end else if (v) begin
            if (s) begin
                mRow = 0;
                mCol = 0;
            end
            img[mRow][mCol] = p;
            if (mRow >= K - 1 && mCol >= K - 1) begin
                pendValid = 1'b1;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        pendWin[PIX_W*(i*K+j) +: PIX_W] = img[mRow-K+1+i][mCol-K+1+j];
                    end
                end
            end
            pendFd = (mRow == IMG_H - 1) && (mCol == IMG_W - 1);
            mCol++;
            if (mCol == IMG_W) begin
                mCol = 0;
                mRow++;
                if (mRow == IMG_H) mRow = 0;
            end
        end
    endtask

    // Move the pending expectation into force at the edge that consumes the drive
    always @(posedge clk) begin
        curValid  <= pendValid;
        curFd     <= pendFd;
        curWinChk <= pendWinChk;
        curWin    <= pendWin;
    end

    // Compare DUT outputs with the model every cycle, mid-period
    always @(negedge clk) begin
        if (checkEn) begin
            check("win_valid", WIN_W'(bus.win_valid), WIN_W'(curValid));
            check("frame_done", WIN_W'(bus.frame_done), WIN_W'(curFd));
            if (curValid || curWinChk) check("win_out", bus.win_out, curWin);
            if (bus.win_valid === 1'b1) begin
                winCount++;
                seenWins.push_back(bus.win_out);
            end
            if (bus.frame_done === 1'b1) fdCount++;
        end
    end

    task automatic sendPixels(input logic [PIX_W-1:0] base, input int first, input int n, input bit gaps);
        for (int k = first; k < first + n; k++) begin
            applyStimulus(1'b1, k == 0, 1'b1, base + PIX_W'((k / IMG_W) * 16 + (k % IMG_W)));
            if (gaps) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic startCase();
        winCount = 0;
        fdCount  = 0;
        seenWins.delete();
    endtask

    task automatic checkOutput(input string name, input int expWins, input int expFd,
                               input int idx, input logic [WIN_W-1:0] expWin);
        idle(2);
        check({name, " windows"}, WIN_W'(winCount), WIN_W'(expWins));
        check({name, " frame_done"}, WIN_W'(fdCount), WIN_W'(expFd));
        if (idx < seenWins.size()) check({name, " literal window"}, seenWins[idx], expWin);
        else check({name, " literal window missing"}, WIN_W'(seenWins.size()), WIN_W'(idx + 1));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;

        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkEn = 1'b1;

        // Case 1: one continuous frame
        startCase();
        sendPixels(8'h00, 0, 16, 1'b0);
        checkOutput("case1", 4, 1, 0, 72'h222120121110020100);

        // Case 2: same frame with an idle cycle after every pixel
        startCase();
        sendPixels(8'h00, 0, 16, 1'b1);
        checkOutput("case2", 4, 1, 0, 72'h222120121110020100);

        // Case 3: two frames back-to-back; window 4 is the second frame's first
        startCase();
        sendPixels(8'h00, 0, 16, 1'b0);
        sendPixels(8'h80, 0, 16, 1'b0);
        checkOutput("case3", 8, 2, 4, 72'hA2A1A0929190828180);

        // Case 4: sof at row 2 col 1 aborts the frame
        startCase();
        sendPixels(8'h00, 0, 9, 1'b0);
        sendPixels(8'h40, 0, 16, 1'b0);
        checkOutput("case4", 4, 1, 0, 72'h626160525150424140);

        // Case 5: reset mid-frame at row 3, then a clean frame
        sendPixels(8'h00, 0, 14, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        startCase();
        sendPixels(8'h00, 0, 16, 1'b0);
        checkOutput("case5", 4, 1, 0, 72'h222120121110020100);

        // Case 6: sof without pix_valid mid-frame is ignored
        startCase();
        sendPixels(8'h00, 0, 6, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hEE);
        sendPixels(8'h00, 6, 10, 1'b0);
        checkOutput("case6", 4, 1, 0, 72'h222120121110020100);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
